// File: rtl/product_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble): 8-bit product in,
// 3-digit BCD out, one shift per clock, valid/ready handshakes on both sides.
module product_bcd_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ena,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] out_bcd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  logic [7:0]  shift_reg;
  logic [11:0] bcd;
  logic [3:0]  cnt;
  logic [10:0] bcd_adj;

  // Only the low 11 bits survive the shift, so the hundreds digit is
  // adjusted modulo 8; the compare still sees the full digit.
  always_comb begin
    bcd_adj = bcd[10:0];
    for (int unsigned i = 0; i < 2; i++) begin
      if (bcd[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    if (bcd[11:8] >= 4'd5)
      bcd_adj[10:8] = bcd[10:8] + 3'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      bcd       <= '0;
      cnt       <= '0;
    end else if (ena) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg <= in_data;
            bcd       <= '0;
            cnt       <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, shift_reg} <= {bcd_adj, shift_reg, 1'b0};
          cnt              <= cnt + 4'd1;
          if (cnt == 4'd7)
            state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && ena && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT);
  assign out_bcd   = bcd;

endmodule

// File: doc/product_bcd_conv.md
PRODUCT_BCD_CONV -- requirements
Module: product_bcd_conv

Interface
REQ-001 Parameters: none; data width SHALL be fixed at 8-bit input, 12-bit (3-digit BCD) output.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  global enable; low freezes all state.
REQ-005 in_data  input  8  unsigned binary product (0..255) from the upstream multiplier.
REQ-006 in_valid  input  1  in_data is valid.
REQ-007 in_ready  output  1  block can accept in_data.
REQ-008 out_bcd  output  12  [11:8] hundreds, [7:4] tens, [3:0] ones.
REQ-009 out_valid  output  1  out_bcd holds a completed conversion.
REQ-010 out_ready  input  1  downstream (display driver) accepts out_bcd.
REQ-011 busy  output  1  high in SHIFT state.

Function
REQ-012 FSM states SHALL be IDLE, SHIFT, DONE; all outputs SHALL be decoded from registered state only (no combinational input-to-output path except as stated in REQ-013).
REQ-013 in_ready SHALL be (state==IDLE) AND ena; out_valid SHALL be (state==DONE); busy SHALL be (state==SHIFT).
REQ-014 Input handshake: on a clk edge with ena=1, state=IDLE, in_valid=1, the block SHALL capture in_data into an 8-bit shift register, clear the 12-bit BCD register and 4-bit counter, and go to SHIFT.
REQ-015 SHIFT, each edge with ena=1: for each BCD digit >=5, add 3 to that digit; then shift {bcd, shift_reg} left one bit; increment counter.
REQ-016 Add-3 adjustment SHALL be applied to the pre-shift values in the same cycle as the shift (one shift per cycle).
REQ-017 After the 8th shift (counter reaches 8), the block SHALL go to DONE; out_bcd SHALL then equal the BCD of the captured value.
REQ-018 Latency: acceptance at edge T -> out_valid high after edge T+8, with ena held high.
REQ-019 DONE: out_bcd and out_valid SHALL hold stable until an edge with ena=1 and out_ready=1, after which state SHALL be IDLE.
REQ-020 No new input SHALL be accepted in SHIFT or DONE (in_ready=0); in_valid in those states SHALL be ignored and SHALL NOT corrupt the conversion.
REQ-021 Output handshake and next input acceptance SHALL NOT occur on the same edge; minimum throughput is one conversion per 10 cycles.
REQ-022 ena=0 on any edge SHALL hold state, counter, shift and BCD registers unchanged; in_ready SHALL be 0; out_valid SHALL keep its value.
REQ-023 out_bcd SHALL retain the last completed result in IDLE until the next conversion enters SHIFT; during SHIFT out_bcd SHALL be the intermediate BCD register (not guaranteed meaningful).
REQ-024 Every digit of a completed result SHALL be 0..9; maximum output 0x255.

Reset
REQ-025 rst_n=0 SHALL asynchronously force state=IDLE, counter=0, shift register=0, BCD register=0.
REQ-026 During reset: out_bcd=0x000, out_valid=0, busy=0; in_ready=0 while rst_n=0, then = ena in IDLE.
REQ-027 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion; no out_valid SHALL appear for the aborted value after release.
REQ-028 Reset release SHALL take effect at the first rising clk edge after rst_n goes high.

Verification
REQ-029 in_data=0xFF accepted, out_ready=1 -> out_valid high 8 edges after acceptance, out_bcd=0x255, state back to IDLE next edge.
REQ-030 Sweep in_data 0..255 back-to-back (in_valid always 1) -> each out_bcd equals decimal of input (e.g. 99->0x099, 100->0x100, 0->0x000); one result per 10 cycles.
REQ-031 in_data=0x2A, out_ready=0 for 5 cycles after out_valid -> out_bcd=0x042 and out_valid held stable all 5 cycles; in_ready=0 throughout.
REQ-032 in_data=0x40 accepted, in_valid=1 with in_data=0x11 during SHIFT -> result 0x064, second value not captured.
REQ-033 in_data=0xC8 accepted, ena=0 for 3 cycles at shift 4 -> out_valid delayed by exactly 3 cycles, out_bcd=0x200.
REQ-034 rst_n pulsed low at shift 5 of in_data=0x7B -> outputs 0x000/out_valid=0 immediately; after release, no out_valid until a new input is accepted.
